// File: rtl/pll_lock_supervisor_if.sv
// Bundle of PLL-facing and status signals for the lock supervisor.
// The supervisor takes the master side: it samples the lock flag and the
// retry request, and drives the PLL reset together with all status outputs.
interface pll_lock_supervisor_if;
  logic       pll_locked;
  logic       retry;
  logic       pll_rst;
  logic       ready;
  logic       fault;
  logic [7:0] lock_lost_cnt;
  logic [2:0] state;

  modport master (
    input  pll_locked,
    input  retry,
    output pll_rst,
    output ready,
    output fault,
    output lock_lost_cnt,
    output state
  );

  modport slave (
    output pll_locked,
    output retry,
    input  pll_rst,
    input  ready,
    input  fault,
    input  lock_lost_cnt,
    input  state
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor, clocked by the PLL reference clock.
// Pulses the PLL reset, waits for lock, demands a stable lock window before
// raising ready, and re-runs the sequence on timeout, glitch or lock loss.
// Consecutive failed attempts latch a fault until an external retry.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// RESET_PLL | pll_rst held high for PLL_RST_CYCLES cycles
// WAIT_LOCK | pll_rst low, waiting up to LOCK_TIMEOUT cycles for locked_s
// STABILIZE | locked_s must stay high for STABLE_CYCLES cycles
// RUN       | ready high; a lock drop restarts the sequence
// FAULT     | retries exhausted; PLL held in reset until retry
module pll_lock_supervisor #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 74250,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 4
) (
  input logic                    refclk,
  input logic                    rst,
  pll_lock_supervisor_if.master  bus
);

  // One shared down-counter serves all three timed states, so size it for the largest.
  localparam int TMAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int TMAX   = (TMAX_A > STABLE_CYCLES) ? TMAX_A : STABLE_CYCLES;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int RW     = $clog2(MAX_RETRIES + 1);

  localparam logic [TW-1:0] RST_LOAD    = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LOAD     = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STB_LOAD    = TW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [RW-1:0]          retry_q, retry_d, retry_inc;
  logic [7:0]             lost_q, lost_d;
  logic                   pll_rst_q, ready_q, fault_q;
  logic                   attempt_fail;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  // Bring the asynchronous lock flag into the refclk domain.
  always_ff @(posedge refclk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Next-state, timer and counter decisions.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    retry_d      = retry_q;
    lost_d       = lost_q;
    attempt_fail = 1'b0;
    retry_inc    = retry_q + RW'(1);

    case (state_q)
      RESET_PLL: begin
        if (timer_q == '0) begin
          state_d = WAIT_LOCK;
          timer_d = TO_LOAD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABILIZE;
          timer_d = STB_LOAD;
        end else if (timer_q == '0) begin
          attempt_fail = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      STABILIZE: begin
        if (!locked_s) begin
          attempt_fail = 1'b1;
        end else if (timer_q == '0) begin
          state_d = RUN;
          retry_d = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      RUN: begin
        // Lock loss after a good lock is a fresh start, not a failed attempt.
        if (!locked_s) begin
          state_d = RESET_PLL;
          timer_d = RST_LOAD;
          if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
        end
      end
      FAULT: begin
        if (bus.retry) begin
          state_d = RESET_PLL;
          timer_d = RST_LOAD;
          retry_d = '0;
        end
      end
      default: begin
        state_d = RESET_PLL;
        timer_d = RST_LOAD;
      end
    endcase

    if (attempt_fail) begin
      retry_d = retry_inc;
      if (retry_inc == RETRY_LIMIT) begin
        state_d = FAULT;
      end else begin
        state_d = RESET_PLL;
        timer_d = RST_LOAD;
      end
    end
  end

  // State register; outputs are registered from the next state so they switch on the transition edge.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= RESET_PLL;
      timer_q   <= RST_LOAD;
      retry_q   <= '0;
      lost_q    <= '0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      lost_q    <= lost_d;
      pll_rst_q <= (state_d == RESET_PLL) || (state_d == FAULT);
      ready_q   <= (state_d == RUN);
      fault_q   <= (state_d == FAULT);
    end
  end

  assign bus.pll_rst       = pll_rst_q;
  assign bus.ready         = ready_q;
  assign bus.fault         = fault_q;
  assign bus.lock_lost_cnt = lost_q;
  assign bus.state         = state_q;

endmodule
